// File: rtl/quiz_pkg.sv
// quiz_pkg: phase codes, LFSR seed and question helpers shared by the quiz controller.
package quiz_pkg;
  localparam logic [3:0] ST_IDLE     = 4'b0000;
  localparam logic [3:0] ST_READY    = 4'b0010;
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;
  localparam logic [3:0] ST_CORRECT  = 4'b0111;
  localparam logic [3:0] ST_WRONG    = 4'b1000;
  localparam logic [3:0] ST_FINISH   = 4'b1111;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_READY    = ST_READY,
    S_QUESTION = ST_QUESTION,
    S_INPUT    = ST_INPUT,
    S_CORRECT  = ST_CORRECT,
    S_WRONG    = ST_WRONG,
    S_FINISH   = ST_FINISH
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // folds 10..15 onto 4..9 so every nibble yields a decimal digit
  function automatic logic [3:0] lfsr_to_digit(input logic [3:0] n);
    return n > 4'd9 ? n - 4'd6 : n;
  endfunction

  function automatic logic [3:0] expected_factors(input logic [3:0] q);
    case (q)
      4'd2, 4'd3, 4'd5, 4'd7: return 4'd1;
      4'd4, 4'd6, 4'd9:       return 4'd2;
      4'd8:                   return 4'd3;
      default:                return 4'd0;
    endcase
  endfunction
endpackage

// File: rtl/quiz_ctrl_sec_timer.sv
// sec_timer: one-second prescaler plus seconds counter, both cleared by clr.
// QUIZ_FAST_SIM_EN bypasses the prescaler so every cycle is a second tick.
module sec_timer #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  output logic       sec_tick,
  output logic [7:0] secs
);
`ifdef QUIZ_FAST_SIM_EN
  assign sec_tick = 1'b1;
`else
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc;
  assign sec_tick = presc == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) presc <= '0;
    else presc <= clr || sec_tick ? '0 : presc + 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) secs <= '0;
    else if (clr) secs <= '0;
    else if (sec_tick) secs <= secs + 8'd1;
endmodule

// File: rtl/quiz_ctrl.sv
// quiz_ctrl: factorization quiz game sequencer driving the 7-segment stage.
// Define QUIZ_FAST_SIM_EN to make every second last a single clock (simulation only).
module quiz_ctrl
  import quiz_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int READY_SEC  = 3,
  parameter int QUE_SEC    = 2,
  parameter int INPUT_SEC  = 5,
  parameter int RESULT_SEC = 2,
  parameter int NUM_ROUNDS = 5
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       nSTART,
  input  logic       nENTER,
  input  logic [3:0] SW,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] DIN,
  output logic [3:0] SCORE,
  output logic [3:0] ROUND
);
  state_t     state, nxt;
  logic [2:0] start_s, enter_s;
  logic       start_p, enter_p, sec_tick, done;
  logic [7:0] secs, dur, lfsr, lfsr_n;
  logic [3:0] que_n, score_n, round_n;

  // bits [1:0] synchronise the key, bit 2 holds the previous synchronised level
  assign start_p = start_s[2] & ~start_s[1];
  assign enter_p = enter_s[2] & ~enter_s[1];
  assign STATE   = state;
  assign dur     = state == S_READY    ? 8'(READY_SEC) :
                   state == S_QUESTION ? 8'(QUE_SEC)   :
                   state == S_INPUT    ? 8'(INPUT_SEC) : 8'(RESULT_SEC);
  assign done    = sec_tick && secs + 8'd1 == dur;

  sec_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk      (CLK),
    .rst_n    (nRST),
    .clr      (nxt != state),
    .sec_tick (sec_tick),
    .secs     (secs)
  );

  always_comb begin
    nxt     = state;
    lfsr_n  = lfsr;
    que_n   = QUE;
    score_n = SCORE;
    round_n = ROUND;
    case (state)
      S_IDLE, S_FINISH: if (start_p) begin
        nxt     = S_READY;
        score_n = 4'd0;
        round_n = 4'd0;
      end
      S_READY:    if (done) nxt = S_QUESTION;
      S_QUESTION: if (done) nxt = S_INPUT;
      S_INPUT:    if (enter_p) nxt = DIN == expected_factors(QUE) ? S_CORRECT : S_WRONG;
                  else if (done) nxt = S_WRONG;
      default:    if (done) nxt = ROUND == 4'(NUM_ROUNDS) ? S_FINISH : S_QUESTION;
    endcase
    // a fresh question is drawn exactly once, on the entry edge
    if (nxt == S_QUESTION && state != S_QUESTION) begin
      lfsr_n  = lfsr_step(lfsr);
      que_n   = lfsr_to_digit(lfsr_n[3:0]);
      round_n = ROUND + 4'd1;
    end
    if (nxt == S_CORRECT && state != S_CORRECT) score_n = SCORE == 4'hF ? SCORE : SCORE + 4'd1;
  end

  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state   <= S_IDLE;
      lfsr    <= LFSR_SEED;
      QUE     <= 4'd0;
      DIN     <= 4'd0;
      SCORE   <= 4'd0;
      ROUND   <= 4'd0;
      start_s <= 3'd0;
      enter_s <= 3'd0;
    end else begin
      state   <= nxt;
      lfsr    <= lfsr_n;
      QUE     <= que_n;
      DIN     <= SW;
      SCORE   <= score_n;
      ROUND   <= round_n;
      start_s <= {start_s[1:0], nSTART};
      enter_s <= {enter_s[1:0], nENTER};
    end
endmodule

// File: tb/tb_quiz_ctrl.sv
// tb_quiz_ctrl: randomized quiz games against a cycle-level game model;
// expected output events are queued by the driver and matched by a monitor.
module tb_quiz_ctrl;
  localparam int TD = 3, NR = 5, RDY = 3, QS = 2, INS = 5, RES = 2;
  localparam logic [3:0] IDLE = 4'h0, READY = 4'h2, QUESTION = 4'h3, INPUT = 4'h4;
  localparam logic [3:0] CORRECT = 4'h7, WRONG = 4'h8, FINISH = 4'hF;

  typedef struct {int c; logic [3:0] st, que, score, round;} ev_t;

  logic CLK = 0, nRST = 0, nSTART = 1, nENTER = 1;
  logic [3:0] SW = 4'h0;
  logic [3:0] STATE, QUE, DIN, SCORE, ROUND;

  ev_t exq[$];
  ev_t ev;
  int cyc = 0, passed = 0, total = 0;
  bit mon_en = 0, first = 1, done = 0;
  logic [3:0] din_exp = 4'h0, din_want;
  logic [15:0] cur, prev;
  logic [7:0] m_lf = 8'hA5;
  logic [3:0] m_que = 0, m_score = 0, m_round = 0;
  int d_plan[16], sw_plan[16], hold_plan[16];

  quiz_ctrl #(.TICK_DIV(TD), .READY_SEC(RDY), .QUE_SEC(QS), .INPUT_SEC(INS),
              .RESULT_SEC(RES), .NUM_ROUNDS(NR)) dut (
    .CLK(CLK), .nRST(nRST), .nSTART(nSTART), .nENTER(nENTER), .SW(SW),
    .STATE(STATE), .QUE(QUE), .DIN(DIN), .SCORE(SCORE), .ROUND(ROUND)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(posedge CLK) din_exp <= nRST ? SW : 4'h0;

  function automatic logic [3:0] factors(input logic [3:0] q);
    int n = q, k = 0;
    for (int f = 2; f <= 9; f++)
      while (n > 1 && n % f == 0) begin n = n / f; k++; end
    return 4'(k);
  endfunction

  function automatic logic [3:0] digit(input logic [7:0] v);
    int n = v % 16;
    return 4'(n > 9 ? n - 6 : n);
  endfunction

  task automatic at(input int p);
    while (cyc < p) begin @(posedge CLK); #1; end
  endtask

  task automatic push(input int c, input logic [3:0] st);
    exq.push_back('{c, st, m_que, m_score, m_round});
  endtask

  task automatic next_question();
    m_lf = {m_lf[6:0], m_lf[7] ^ m_lf[5] ^ m_lf[4] ^ m_lf[3]};
    m_que = digit(m_lf);
    m_round = m_round + 4'd1;
  endtask

  // keys are driven just after an edge; the game reacts three edges later
  task automatic play_game(input int ps, input int rst_r, input int mid_r, output int fin);
    int t, i, d, tr;
    logic [3:0] sw;
    bit ok;
    t = ps + 3;
    m_score = 0;
    m_round = 0;
    push(t, READY);
    at(ps); nSTART = 0;
    at(ps + 3); nSTART = 1;
    t += RDY * TD;
    next_question();
    push(t, QUESTION);
    for (int r = 1; r <= NR; r++) begin
      i = t + QS * TD;
      push(i, INPUT);
      if (r == mid_r) begin at(t + 1); nSTART = 0; at(t + 4); nSTART = 1; end
      if (r == rst_r) begin
        m_lf = 8'hA5; m_que = 0; m_score = 0; m_round = 0;
        push(i + 1, IDLE);
        at(i + 1); nRST = 0;
        at(i + 3); nRST = 1;
        fin = i + 3;
        return;
      end
      d = d_plan[r];
      ok = 0;
      tr = i + INS * TD;
      sw = sw_plan[r] == -1 ? factors(m_que) :
           sw_plan[r] == -2 ? 4'($urandom_range(0, 15)) : 4'(sw_plan[r]);
      if (d >= 0 && d + 3 <= INS * TD) begin
        tr = i + d + 3;
        ok = sw == factors(m_que);
      end
      if (ok) m_score = m_score == 4'd15 ? m_score : m_score + 4'd1;
      push(tr, ok ? CORRECT : WRONG);
      t = tr + RES * TD;
      if (r == NR) push(t, FINISH);
      else begin next_question(); push(t, QUESTION); end
      if (d >= 0) begin
        at(i + d); SW = sw; nENTER = 0;
        at(i + d + 2); SW = 4'($urandom_range(0, 15));
        at(i + d + hold_plan[r]); nENTER = 1;
      end
    end
    fin = t;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      cur = {STATE, QUE, SCORE, ROUND};
      if (first) begin
        first = 0;
        total++;
        if (cur === 16'h0 && DIN === 4'h0) passed++;
        else $display("FAIL reset_state: got st=%h que=%h score=%h round=%h din=%h, want all 0",
                      STATE, QUE, SCORE, ROUND, DIN);
        prev = 16'h0;
      end else if (cur !== prev) begin
        total++;
        if (exq.size() == 0)
          $display("FAIL unexpected_event cyc=%0d: got st=%h que=%h score=%h round=%h",
                   cyc, STATE, QUE, SCORE, ROUND);
        else begin
          ev = exq.pop_front();
          if (ev.c == cyc && cur === {ev.st, ev.que, ev.score, ev.round}) passed++;
          else $display("FAIL event: got cyc=%0d st=%h que=%h score=%h round=%h, want cyc=%0d st=%h que=%h score=%h round=%h",
                        cyc, STATE, QUE, SCORE, ROUND, ev.c, ev.st, ev.que, ev.score, ev.round);
        end
        prev = cur;
      end
      total++;
      din_want = nRST ? din_exp : 4'h0;
      if (DIN === din_want) passed++;
      else $display("FAIL din cyc=%0d: got %h want %h", cyc, DIN, din_want);
      if (done) begin
        total++;
        if (exq.size() == 0) passed++;
        else $display("FAIL missing_events: %0d expected events never seen, next at cyc=%0d", exq.size(), exq[0].c);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
      end
    end
  end

  initial begin
    int fin;
    at(3); nRST = 1; mon_en = 1;
    d_plan[1] = $urandom_range(0, 5); sw_plan[1] = 2;  hold_plan[1] = 3;
    d_plan[2] = 2;                    sw_plan[2] = 3;  hold_plan[2] = 2;
    d_plan[3] = -1;                   sw_plan[3] = -2; hold_plan[3] = 2;
    d_plan[4] = INS * TD - 3;         sw_plan[4] = -1; hold_plan[4] = 2;
    d_plan[5] = 1;                    sw_plan[5] = -1; hold_plan[5] = 10;
    play_game(5, 0, 2, fin);
    for (int g = 0; g < 5; g++) begin
      for (int r = 1; r <= NR; r++) begin
        d_plan[r] = $urandom_range(0, 15);
        if (d_plan[r] == 15) d_plan[r] = -1;
        sw_plan[r] = $urandom_range(0, 1) == 1 ? -1 : -2;
        hold_plan[r] = $urandom_range(2, 5);
      end
      play_game(fin + $urandom_range(2, 5), g == 1 ? 3 : 0, 0, fin);
    end
    at(fin + 5);
    done = 1;
  end
endmodule

// File: doc/quiz_ctrl.md
Name: quiz_ctrl

Overview:
- Game controller for the factorization quiz. It sits directly upstream of the 7-segment stage and drives its STATE, QUE and DIN inputs.
- Sequences each game as IDLE → READY → (QUESTION → INPUT → CORRECT/WRONG) × NUM_ROUNDS → FINISH.
- Generates pseudo-random question digits 0–9, times each phase in seconds, judges the player's switch answer and keeps score.

Parameters:
- TICK_DIV, 50_000_000 — CLK cycles per 1-second tick.
- READY_SEC, 3 — seconds spent in READY.
- QUE_SEC, 2 — seconds the question is shown.
- INPUT_SEC, 5 — answer window in seconds.
- RESULT_SEC, 2 — seconds CORRECT/WRONG is shown.
- NUM_ROUNDS, 5 — questions per game (1..15).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- nSTART  in  1  raw start key, active-low, asynchronous to CLK.
- nENTER  in  1  raw enter key, active-low, asynchronous to CLK.
- SW  in  4  player answer switches.
- STATE  out  4  phase code for the display stage.
- QUE  out  4  current question digit, 0..9.
- DIN  out  4  registered copy of SW.
- SCORE  out  4  correct answers in the current game.
- ROUND  out  4  current round number, 1-based; 0 in IDLE.

Behaviour:
- Reset (asynchronous, nRST=0): STATE=4'b0000, QUE=0, DIN=0, SCORE=0, ROUND=0, LFSR=8'hA5, timer and edge detectors cleared. Reset mid-game aborts to IDLE; nothing is retained.
- Keys: 2-flop synchronizer, then falling-edge detect produces a 1-cycle pulse (start_p, enter_p). A held key gives one pulse only.
- DIN = SW registered every cycle (1-cycle latency) in all states.
- Timer: prescaler counts 0..TICK_DIV-1, sec_tick on wrap. The seconds counter and prescaler clear on every state change, so every phase lasts exactly N×TICK_DIV cycles, measured from the entry cycle.
- State codes: IDLE 0000, READY 0010, QUESTION 0011, INPUT 0100, CORRECT 0111, WRONG 1000, FINISH 1111.
- IDLE: start_p → READY; ROUND=0, SCORE=0.
- READY: after READY_SEC → QUESTION with ROUND=1.
- QUESTION: after QUE_SEC → INPUT.
- INPUT:
  - enter_p → CORRECT if DIN==expected(QUE), else WRONG.
  - Timeout after INPUT_SEC → WRONG.
  - enter_p in the same cycle as the timeout: enter is judged, timeout ignored.
  - Judging uses the DIN value present in the enter_p cycle.
- CORRECT: SCORE+1 on entry, saturating at 15.
- CORRECT/WRONG: after RESULT_SEC → FINISH if ROUND==NUM_ROUNDS; otherwise → QUESTION with ROUND+1.
- FINISH: start_p → READY and a new game (SCORE=0, ROUND=0). QUE holds its last value.
- start_p in any state other than IDLE/FINISH is ignored. enter_p outside INPUT is ignored.
- Question generation:
  - 8-bit Fibonacci LFSR: shift left, feedback bit0 = b7^b5^b4^b3.
  - Advances exactly once on each entry to QUESTION.
  - QUE is taken from the new value: n = lfsr[3:0]; QUE = n if n<=9, else n-6.
- expected(QUE) = prime-factor count with multiplicity: 0,1→0; 2,3,5,7→1; 4,6,9→2; 8→3.
- The FSM is a single registered state; all outputs are registered.

Optional Feature:
- QUIZ_FAST_SIM_EN defined: the prescaler is bypassed and sec_tick=1 every cycle, so each phase lasts N cycles. Used for simulation.
- Undefined: normal TICK_DIV prescaling.
- Nothing else changes.

Decomposition:
- quiz_pkg holds:
  - state code localparams (ST_IDLE..ST_FINISH);
  - LFSR_SEED=8'hA5;
  - function expected_factors(input [3:0] q);
  - function lfsr_to_digit.
- One sub-module, sec_timer: prescaler plus seconds counter. Inputs clr and TICK_DIV; outputs sec_tick and the seconds count.

Test Plan:
1. Reset then start, QUIZ_FAST_SIM_EN on: STATE 0000 → 0010 for 3 cycles → 0011 with QUE=4 (LFSR 8'h4A), ROUND=1.
2. Round 1 at QUE=4: SW=2, press enter in INPUT → STATE 0111, SCORE=1. Round 2 gives QUE=5 (LFSR 8'h95).
3. Round 2, SW=3, enter → 1000, SCORE unchanged. Repeat the round with no enter → WRONG after exactly 5 ticks.
4. Enter pulse coincident with the INPUT timeout tick, correct SW → CORRECT, not WRONG. Enter held low for 10 cycles → one judgement only.
5. Play 5 rounds → STATE=1111, ROUND=5. Start pressed mid-QUESTION is ignored. Start in FINISH → READY with SCORE=0, ROUND=0.
6. Assert nRST during INPUT in round 3 → all outputs reset immediately (asynchronous). The next game's first QUE is 4 again.
